// File: rtl/ili9341_spi_sink.sv
// ILI9341 4-wire SPI write-stream receiver: decodes CASET/PASET/RAMWR into
// windowed pixel writes with (x, y) coordinates; other commands are only reported.
module ili9341_spi_sink #(
  parameter int WIDTH       = 240,
  parameter int HEIGHT      = 320,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        spi_sck,
  input  logic        spi_mosi,
  input  logic        spi_cs,
  input  logic        spi_dc,
  output logic        cmd_valid,
  output logic [7:0]  cmd_byte,
  output logic        pix_valid,
  output logic [8:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [15:0] pix_data,
  output logic        frame_done,
  output logic        sync_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {S_IDLE, S_CASET, S_PASET, S_RAMWR, S_SKIP} state_t;

  localparam logic [8:0] EC_RST = 9'(WIDTH - 1);
  localparam logic [8:0] EP_RST = 9'(HEIGHT - 1);
  localparam logic [9:0] LIM_X  = 10'(WIDTH);
  localparam logic [9:0] LIM_Y  = 10'(HEIGHT);

  logic [SYNC_STAGES-1:0] r_sck_s, r_mosi_s, r_cs_s, r_dc_s;
  logic       r_sck_d, r_cs_d;
  logic [6:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic       r_byte_stb, r_byte_dc;
  logic [7:0] r_byte;

  state_t     r_state;
  logic [8:0] r_sc, r_ec, r_sp, r_ep, r_cx, r_cy;
  logic [2:0] r_pcnt;
  logic       r_p0, r_p2;
  logic [7:0] r_p1, r_hi;
  logic       r_phase;

  logic w_sck, w_mosi, w_cs, w_dc, w_rise;
  logic w_x_wrap, w_y_wrap, w_in_range;

  assign w_sck      = r_sck_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_cs       = r_cs_s[SYNC_STAGES-1];
  assign w_dc       = r_dc_s[SYNC_STAGES-1];
  assign w_rise     = w_sck & ~r_sck_d;
  assign w_x_wrap   = (r_cx >= r_ec);
  assign w_y_wrap   = (r_cy >= r_ep);
  assign w_in_range = ({1'b0, r_cx} < LIM_X) && ({1'b0, r_cy} < LIM_Y);
  assign dbg_state  = r_state;

  // Synchronizers, bit capture and byte framing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sck_s    <= '0;
      r_mosi_s   <= '0;
      r_cs_s     <= '1;
      r_dc_s     <= '0;
      r_sck_d    <= 1'b0;
      r_cs_d     <= 1'b1;
      r_shift    <= '0;
      r_bit_cnt  <= '0;
      r_byte_stb <= 1'b0;
      r_byte     <= '0;
      r_byte_dc  <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      r_sck_s    <= {r_sck_s[SYNC_STAGES-2:0], spi_sck};
      r_mosi_s   <= {r_mosi_s[SYNC_STAGES-2:0], spi_mosi};
      r_cs_s     <= {r_cs_s[SYNC_STAGES-2:0], spi_cs};
      r_dc_s     <= {r_dc_s[SYNC_STAGES-2:0], spi_dc};
      r_sck_d    <= w_sck;
      r_cs_d     <= w_cs;
      r_byte_stb <= 1'b0;
      sync_err   <= 1'b0;
      if (w_cs) begin
        r_bit_cnt <= '0;
        // A deselect that lands between byte boundaries loses the partial byte.
        sync_err  <= ~r_cs_d & (r_bit_cnt != 3'd0);
      end else if (w_rise) begin
        r_shift   <= {r_shift[5:0], w_mosi};
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (r_bit_cnt == 3'd7) begin
          r_byte_stb <= 1'b1;
          r_byte     <= {r_shift, w_mosi};
          r_byte_dc  <= w_dc;
        end
      end
    end
  end

  // Command decode, window registers, pixel assembly and cursor.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_sc       <= '0;
      r_ec       <= EC_RST;
      r_sp       <= '0;
      r_ep       <= EP_RST;
      r_cx       <= '0;
      r_cy       <= '0;
      r_pcnt     <= '0;
      r_p0       <= 1'b0;
      r_p1       <= '0;
      r_p2       <= 1'b0;
      r_hi       <= '0;
      r_phase    <= 1'b0;
      cmd_valid  <= 1'b0;
      cmd_byte   <= '0;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_data   <= '0;
      frame_done <= 1'b0;
    end else begin
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (r_byte_stb) begin
        if (!r_byte_dc) begin
          cmd_valid <= 1'b1;
          cmd_byte  <= r_byte;
          r_pcnt    <= '0;
          r_phase   <= 1'b0;
          case (r_byte)
            8'h2A: r_state <= S_CASET;
            8'h2B: r_state <= S_PASET;
            8'h2C: begin
              r_state <= S_RAMWR;
              r_cx    <= r_sc;
              r_cy    <= r_sp;
            end
            default: r_state <= S_SKIP;
          endcase
        end else begin
          case (r_state)
            S_CASET, S_PASET: begin
              // Only the low 9 bits of each 16-bit coordinate are kept.
              if (r_pcnt != 3'd4) begin
                r_pcnt <= r_pcnt + 3'd1;
                case (r_pcnt[1:0])
                  2'd0: r_p0 <= r_byte[0];
                  2'd1: r_p1 <= r_byte;
                  2'd2: r_p2 <= r_byte[0];
                  default: begin
                    if (r_state == S_CASET) begin
                      r_sc <= {r_p0, r_p1};
                      r_ec <= {r_p2, r_byte};
                    end else begin
                      r_sp <= {r_p0, r_p1};
                      r_ep <= {r_p2, r_byte};
                    end
                  end
                endcase
              end
            end
            S_RAMWR: begin
              if (!r_phase) begin
                r_hi    <= r_byte;
                r_phase <= 1'b1;
              end else begin
                r_phase   <= 1'b0;
                pix_data  <= {r_hi, r_byte};
                pix_x     <= r_cx;
                pix_y     <= r_cy;
                pix_valid <= w_in_range;
                if (w_x_wrap) begin
                  r_cx <= r_sc;
                  if (w_y_wrap) begin
                    r_cy       <= r_sp;
                    frame_done <= 1'b1;
                  end else begin
                    r_cy <= r_cy + 9'd1;
                  end
                end else begin
                  r_cx <= r_cx + 9'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ili9341_spi_sink.sv
// Bench for ili9341_spi_sink: directed byte table, hand-written corner sequences,
// and randomized command/data streams checked against a byte-level panel model.
`timescale 1ns/1ps
module tb_ili9341_spi_sink;

  localparam int MW = 240;
  localparam int MH = 320;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic spi_sck = 1'b0, spi_mosi = 1'b0, spi_cs = 1'b1, spi_dc = 1'b0;
  logic cmd_valid, pix_valid, frame_done, sync_err;
  logic [7:0] cmd_byte;
  logic [8:0] pix_x, pix_y;
  logic [15:0] pix_data;
  logic [2:0] dbg_state;
  logic s_cmd_valid, s_pix_valid, s_frame_done, s_sync_err;
  logic [7:0] s_cmd_byte;
  logic [8:0] s_pix_x, s_pix_y;
  logic [15:0] s_pix_data;
  logic [2:0] s_dbg_state;

  ili9341_spi_sink u_dut (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte), .pix_valid(pix_valid),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .frame_done(frame_done),
    .sync_err(sync_err), .dbg_state(dbg_state)
  );

  // Small panel sharing the same SPI stream, used for a complete-frame run.
  ili9341_spi_sink #(.WIDTH(16), .HEIGHT(12)) u_small (
    .clk(clk), .rst(rst), .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_cs(spi_cs),
    .spi_dc(spi_dc), .cmd_valid(s_cmd_valid), .cmd_byte(s_cmd_byte), .pix_valid(s_pix_valid),
    .pix_x(s_pix_x), .pix_y(s_pix_y), .pix_data(s_pix_data), .frame_done(s_frame_done),
    .sync_err(s_sync_err), .dbg_state(s_dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  int last_rise = 0;

  // ---------------- scoreboard ----------------
  logic [35:0] exp_q[$];
  logic [7:0]  exp_cmd_q[$];
  logic [35:0] got_pix_q[$];
  logic [7:0]  got_cmd_q[$];
  int got_err = 0, exp_err = 0;
  int s_cnt = 0, s_fd_cnt = 0, s_fd_at = 0;
  logic s_fd_with_pix = 1'b0;
  logic [8:0] s_last_x = '0, s_last_y = '0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  function automatic logic [35:0] mk(logic v, logic fd, int x, int y, logic [15:0] d);
    return {v, fd, 9'(x), 9'(y), d};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid) begin
        got_cmd_q.push_back(cmd_byte);
        check("cmd_latency", 64'(cyc - last_rise), 64'd4);
      end
      if (pix_valid || frame_done) begin
        got_pix_q.push_back({pix_valid, frame_done, pix_x, pix_y, pix_data});
        check("pix_latency", 64'(cyc - last_rise), 64'd4);
      end
      if (sync_err) got_err++;
      if (s_pix_valid) begin
        s_cnt++;
        s_last_x = s_pix_x;
        s_last_y = s_pix_y;
      end
      if (s_frame_done) begin
        s_fd_cnt++;
        s_fd_at = s_cnt;
        s_fd_with_pix = s_pix_valid;
      end
    end
  end

  // ---------------- reference model ----------------
  int m_state, m_sc, m_ec, m_sp, m_ep, m_cx, m_cy;  // state: 0 idle 1 caset 2 paset 3 ramwr 4 skip
  int m_par[$];
  logic [7:0] m_hi;
  logic m_hi_ok;

  task automatic model_reset();
    m_state = 0; m_sc = 0; m_ec = MW - 1; m_sp = 0; m_ep = MH - 1;
    m_cx = 0; m_cy = 0; m_par.delete(); m_hi_ok = 1'b0;
  endtask

  task automatic model_byte(input logic dc, input logic [7:0] b);
    int s, e;
    logic v, xw, fd;
    if (!dc) begin
      exp_cmd_q.push_back(b);
      m_par.delete();
      m_hi_ok = 1'b0;
      case (b)
        8'h2A: m_state = 1;
        8'h2B: m_state = 2;
        8'h2C: begin m_state = 3; m_cx = m_sc; m_cy = m_sp; end
        default: m_state = 4;
      endcase
    end else if (m_state == 1 || m_state == 2) begin
      if (m_par.size() < 4) begin
        m_par.push_back(int'(b));
        if (m_par.size() == 4) begin
          s = (m_par[0] * 256 + m_par[1]) % 512;
          e = (m_par[2] * 256 + m_par[3]) % 512;
          if (m_state == 1) begin m_sc = s; m_ec = e; end
          else begin m_sp = s; m_ep = e; end
        end
      end
    end else if (m_state == 3) begin
      if (!m_hi_ok) begin
        m_hi = b;
        m_hi_ok = 1'b1;
      end else begin
        v  = (m_cx < MW) && (m_cy < MH);
        xw = (m_cx >= m_ec);
        fd = xw && (m_cy >= m_ep);
        if (v || fd) exp_q.push_back(mk(v, fd, m_cx, m_cy, {m_hi, b}));
        if (xw) begin
          m_cx = m_sc;
          m_cy = (m_cy >= m_ep) ? m_sp : m_cy + 1;
        end else begin
          m_cx = m_cx + 1;
        end
        m_hi_ok = 1'b0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic spi_bit(input logic v);
    @(posedge clk); #1; spi_sck = 1'b0; spi_mosi = v;
    @(posedge clk); @(posedge clk); #1; spi_sck = 1'b1; last_rise = cyc;
    @(posedge clk);
  endtask

  task automatic send_byte(input logic dc, input logic [7:0] b);
    @(posedge clk); #1; spi_dc = dc; spi_cs = 1'b0;
    for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    @(posedge clk); #1; spi_sck = 1'b0;
    model_byte(dc, b);
  endtask

  task automatic send_pixel(input logic [15:0] d);
    send_byte(1'b1, d[15:8]);
    send_byte(1'b1, d[7:0]);
  endtask

  task automatic cs_pulse();
    @(posedge clk); #1; spi_sck = 1'b0;
    repeat (2) @(posedge clk);
    #1; spi_cs = 1'b1;
    repeat (4) @(posedge clk);
    #1; spi_cs = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  task automatic clear_all();
    exp_q.delete(); exp_cmd_q.delete(); got_pix_q.delete(); got_cmd_q.delete();
    got_err = 0; exp_err = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; spi_sck = 1'b0; spi_cs = 1'b1; rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data,
                         frame_done, sync_err, dbg_state}, 64'd0);
    check("reset_small", {s_cmd_valid, s_cmd_byte, s_pix_valid, s_pix_x, s_pix_y,
                          s_pix_data, s_frame_done, s_sync_err, s_dbg_state}, 64'd0);
    @(posedge clk); #1; rst = 1'b1;
    model_reset();
    clear_all();
    repeat (4) @(posedge clk);
  endtask

  task automatic compare_events(input string tag);
    logic [35:0] m;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check({tag, "_cmd_cnt"}, 64'(got_cmd_q.size()), 64'(exp_cmd_q.size()));
    for (int i = 0; i < exp_cmd_q.size() && i < got_cmd_q.size(); i++)
      check({tag, "_cmd"}, 64'(got_cmd_q[i]), 64'(exp_cmd_q[i]));
    check({tag, "_pix_cnt"}, 64'(got_pix_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_pix_q.size(); i++) begin
      m = exp_q[i][35] ? '1 : 36'hC_0000_0000;
      check({tag, "_pix"}, 64'(got_pix_q[i] & m), 64'(exp_q[i] & m));
    end
    check({tag, "_sync_err"}, 64'(got_err), 64'(exp_err));
    exp_q.delete(); exp_cmd_q.delete(); got_pix_q.delete(); got_cmd_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic dc; logic [7:0] b; int kind; int x; int y; logic [15:0] d; logic fd;
  } vec_t;  // kind: 0 quiet, 1 command, 2 pixel
  vec_t tbl[$];

  task automatic add(input logic dc, input logic [7:0] b, input int kind,
                     input int x, input int y, input logic [15:0] d, input logic fd);
    tbl.push_back('{dc, b, kind, x, y, d, fd});
  endtask

  initial begin
    #5ms;
    failures++;
    $display("FAIL watchdog: time limit reached at cycle %0d, want completion", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb;
    int op, n, s, e;
    logic [7:0] pb[6];

    add(0, 8'h2C, 1, 0, 0, 0, 0);
    add(1, 8'hF8, 0, 0, 0, 0, 0);
    add(1, 8'h00, 2, 0, 0, 16'hF800, 0);
    add(1, 8'h07, 0, 0, 0, 0, 0);
    add(1, 8'hE0, 2, 1, 0, 16'h07E0, 0);
    add(0, 8'h2A, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h0A, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h0B, 0, 0, 0, 0, 0);
    add(0, 8'h2B, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h14, 0, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h15, 0, 0, 0, 0, 0);
    add(0, 8'h2C, 1, 0, 0, 0, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h01, 2, 10, 20, 16'h0001, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h02, 2, 11, 20, 16'h0002, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h03, 2, 10, 21, 16'h0003, 0);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h04, 2, 11, 21, 16'h0004, 1);
    add(1, 8'h00, 0, 0, 0, 0, 0); add(1, 8'h05, 2, 10, 20, 16'h0005, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].dc, tbl[i].b);
      repeat (8) @(posedge clk);
      @(negedge clk);
      if (tbl[i].kind == 0) begin
        check($sformatf("tbl%0d_quiet", i), 64'(got_pix_q.size() + got_cmd_q.size()), 64'd0);
      end else if (tbl[i].kind == 1) begin
        check($sformatf("tbl%0d_cmd_cnt", i), 64'(got_cmd_q.size()), 64'd1);
        if (got_cmd_q.size() > 0)
          check($sformatf("tbl%0d_cmd", i), 64'(got_cmd_q[0]), 64'(tbl[i].b));
      end else begin
        check($sformatf("tbl%0d_pix_cnt", i), 64'(got_pix_q.size()), 64'd1);
        if (got_pix_q.size() > 0)
          check($sformatf("tbl%0d_pix", i), 64'(got_pix_q[0]),
                64'(mk(1'b1, tbl[i].fd, tbl[i].x, tbl[i].y, tbl[i].d)));
      end
      exp_q.delete(); exp_cmd_q.delete(); got_pix_q.delete(); got_cmd_q.delete();
    end
    check("tbl_sync_err", 64'(got_err), 64'd0);

    // Clipping at the right panel edge, then wrap to the window start on row 1.
    do_reset();
    send_byte(0, 8'h2A);
    send_byte(1, 8'h00); send_byte(1, 8'hEE); send_byte(1, 8'h00); send_byte(1, 8'hF1);
    send_byte(0, 8'h2C);
    send_pixel(16'h1111); send_pixel(16'h2222); send_pixel(16'h3333); send_pixel(16'h4444);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 238, 0, 16'h1111));
    exp_q.push_back(mk(1, 0, 239, 0, 16'h2222));
    compare_events("clip");
    send_pixel(16'h5555);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 238, 1, 16'h5555));
    compare_events("clip_wrap");

    // Deselect after 5 bits, then a clean PASET command.
    for (int i = 0; i < 5; i++) spi_bit(1'($urandom_range(0, 1)));
    cs_pulse();
    exp_err++;
    send_byte(0, 8'h2B);
    compare_events("sync_err");

    // Partial CASET followed by a command leaves the window untouched.
    do_reset();
    send_byte(0, 8'h2A); send_byte(1, 8'h00); send_byte(1, 8'h05);
    send_byte(0, 8'h2C);
    send_pixel(16'h0021); send_pixel(16'h0022);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 0, 16'h0021));
    exp_q.push_back(mk(1, 0, 1, 0, 16'h0022));
    compare_events("partial_caset");
    send_byte(0, 8'h2A);
    send_byte(1, 8'h00); send_byte(1, 8'h05); send_byte(1, 8'h00); send_byte(1, 8'h06);
    send_byte(0, 8'h2C);
    send_pixel(16'hABCD);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 5, 0, 16'hABCD));
    compare_events("narrow_window");

    // Asynchronous reset in the middle of a pixel.
    send_byte(1, 8'h12);
    for (int i = 0; i < 3; i++) spi_bit(1'b1);
    @(posedge clk); #1; spi_sck = 1'b0;
    @(posedge clk); #3; rst = 1'b0; spi_cs = 1'b1;
    #1;
    check("rst_async", {cmd_valid, cmd_byte, pix_valid, pix_x, pix_y, pix_data,
                        frame_done, sync_err, dbg_state}, 64'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    model_reset();
    clear_all();
    repeat (4) @(posedge clk);
    send_byte(0, 8'h2C);
    send_pixel(16'h3456); send_pixel(16'h789A);
    exp_q.delete();
    exp_q.push_back(mk(1, 0, 0, 0, 16'h3456));
    exp_q.push_back(mk(1, 0, 1, 0, 16'h789A));
    compare_events("after_reset");

    // Complete default-window frame on the 16x12 panel.
    do_reset();
    s_cnt = 0; s_fd_cnt = 0; s_fd_at = 0; s_fd_with_pix = 1'b0;
    send_byte(0, 8'h2C);
    for (int i = 0; i < 16 * 12; i++) send_pixel(16'($urandom_range(0, 65535)));
    compare_events("frame_main");
    check("frame_count", 64'(s_cnt), 64'd192);
    check("frame_last_xy", 64'({s_last_x, s_last_y}), 64'({9'd15, 9'd11}));
    check("frame_done_cnt", 64'(s_fd_cnt), 64'd1);
    check("frame_done_at", 64'({s_fd_with_pix, 32'(s_fd_at)}), 64'({1'b1, 32'd192}));
    send_pixel(16'h0BAD);
    compare_events("frame_next_main");
    check("frame_next_xy", 64'({s_last_x, s_last_y}), 64'd0);
    check("frame_next_cnt", 64'({32'(s_cnt), 32'(s_fd_cnt)}), 64'({32'd193, 32'd1}));

    // Randomized command/data streams against the model.
    do_reset();
    for (int k = 0; k < 80; k++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        if (op == 2) begin s = $urandom_range(310, 325); e = s + $urandom_range(0, 2); end
        else begin s = $urandom_range(230, 245); e = s + $urandom_range(0, 3); end
        pb[0] = 8'(s >> 8); pb[1] = 8'(s); pb[2] = 8'(e >> 8); pb[3] = 8'(e);
        if ($urandom_range(0, 3) == 0) begin
          pb[0] = 8'($urandom_range(0, 3)); pb[2] = 8'($urandom_range(0, 3));
          pb[1] = 8'($urandom_range(0, 255)); pb[3] = 8'($urandom_range(0, 255));
        end
        pb[4] = 8'($urandom_range(0, 255)); pb[5] = 8'($urandom_range(0, 255));
        n = $urandom_range(2, 6);
        send_byte(0, (op == 2) ? 8'h2B : 8'h2A);
        for (int j = 0; j < n; j++) send_byte(1, pb[j]);
      end else if (op <= 6) begin
        send_byte(0, 8'h2C);
        n = $urandom_range(0, 9);
        for (int j = 0; j < n; j++) send_byte(1, 8'($urandom_range(0, 255)));
      end else if (op == 7) begin
        rb = 8'($urandom_range(0, 255));
        if (rb >= 8'h2A && rb <= 8'h2C) rb = 8'h36;
        send_byte(0, rb);
        n = $urandom_range(0, 3);
        for (int j = 0; j < n; j++) send_byte(1, 8'($urandom_range(0, 255)));
      end else if (op == 8) begin
        n = $urandom_range(1, 3);
        for (int j = 0; j < n; j++) send_byte(1, 8'($urandom_range(0, 255)));
      end else begin
        cs_pulse();
      end
      compare_events($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ili9341_spi_sink.md
Name: ili9341_spi_sink

Overview:
- SPI target that receives the 4-wire ILI9341 write stream (sck, mosi, cs, dc) and decodes it into pixel writes with (x, y) coordinates.
- Handles CASET (0x2A), PASET (0x2B) and RAMWR (0x2C). All other commands and their parameters are reported but not interpreted.
- Serves as the display-side counterpart of the panel driver: an on-chip panel model for loopback verification, and a capture front-end that feeds a framebuffer or checker.

Parameters:
- WIDTH, 240, panel columns; pixels with x >= WIDTH are clipped.
- HEIGHT, 320, panel rows; pixels with y >= HEIGHT are clipped.
- SYNC_STAGES, 2, flip-flop stages on each SPI input (minimum 2).

Ports:
- clk  in  1  system clock; spi_sck frequency must be <= clk/4
- rst  in  1  asynchronous reset, active-low
- spi_sck  in  1  SPI clock, mode 0, idle low
- spi_mosi  in  1  serial data, MSB first
- spi_cs  in  1  chip select, active-low
- spi_dc  in  1  0 = command byte, 1 = data byte
- cmd_valid  out  1  one-clk pulse per received command byte
- cmd_byte  out  8  last command byte; held until the next command
- pix_valid  out  1  one-clk pulse per accepted, in-range pixel
- pix_x  out  9  column of the pixel
- pix_y  out  9  row of the pixel
- pix_data  out  16  RGB565 value, first byte in [15:8]
- frame_done  out  1  one-clk pulse when the RAMWR cursor wraps past the window end
- sync_err  out  1  one-clk pulse when cs deasserts mid-byte

Behaviour:
- Reset (async assert, sync deassert):
  - All outputs are 0.
  - Window resets to SC=0, EC=WIDTH-1, SP=0, EP=HEIGHT-1.
  - Cursor = (0,0); FSM = IDLE; bit counter = 0.
- Input sync:
  - sck, mosi, cs and dc each pass through SYNC_STAGES flip-flops.
  - A sck rise is detected from the last two synchronized sck samples.
- Bit capture (sck rise while synced cs = 0):
  - Shift mosi into the byte shift register, MSB first.
  - On the 8th bit, sample synced dc and raise an internal byte strobe the following clk cycle.
- cs = 1:
  - The bit counter is held at 0.
  - A rising edge of cs with bit counter != 0 discards the partial byte and pulses sync_err.
  - The FSM state is preserved across cs toggles; only a new command changes state.
- Command byte (dc = 0), in any state:
  - cmd_valid pulses and cmd_byte is updated on the cycle after the byte strobe.
  - Next state: 0x2A -> CASET, 0x2B -> PASET, 0x2C -> RAMWR (cursor loads (SC,SP), pixel byte phase = high), any other -> SKIP.
  - A partial CASET/PASET parameter set is discarded; window registers keep their old values.
- CASET / PASET data bytes:
  - Four bytes in order: start hi, start lo, end hi, end lo.
  - Each value is 16 bits; the low 9 bits are stored.
  - Window registers commit only when the 4th byte arrives.
  - Further data bytes are ignored, and the state stays the same.
- RAMWR data bytes:
  - Even-numbered byte goes to pix_data[15:8], odd-numbered byte to [7:0].
  - When the odd byte arrives, the pixel is emitted on the cycle after its byte strobe (pixel latency = 1 clk after the byte strobe).
  - pix_valid = 1 only if x < WIDTH and y < HEIGHT; a clipped pixel still advances the cursor.
- Cursor advance after each pixel:
  - If x == EC (or x > EC): x <- SC and y advances.
  - Else x <- x+1.
  - When y advances from y == EP (or y > EP): y <- SP and frame_done pulses in the same cycle as that pixel.
  - When the window is 1x1, every pixel produces frame_done.
- SKIP / IDLE: data bytes are ignored with no output.
- A stray odd RAMWR byte interrupted by a command is dropped.
- Reset mid-operation: all state clears immediately and the window returns to full-screen defaults.

Test Plan:
- Reset with cs = 1, then send 0x2C (dc=0) followed by 4 data bytes F8 00 07 E0 -> cmd_valid with cmd_byte = 0x2C; pix (0,0) = 0xF800, then pix (1,0) = 0x07E0; no sync_err.
- CASET 00 0A 00 0B, PASET 00 14 00 15, RAMWR plus 5 pixels (0x0001..0x0005) -> emitted coordinates (10,20), (11,20), (10,21), (11,21), (10,20); frame_done pulses with the 4th pixel only.
- RAMWR with the full default window, 240x320 pixels -> exactly 76800 pix_valid pulses; last pixel at (239,319); frame_done once, coincident with the last pixel; cursor back at (0,0).
- CASET 00 EE 00 F1 then RAMWR plus 4 pixels -> pix_valid only for x = 238 and 239; the x = 240 and 241 pixels are clipped; cursor then wraps to (238,1).
- Raise cs after 5 bits, then send a full byte 0x2B -> sync_err pulses once; the next byte decodes cleanly as PASET (cmd_byte = 0x2B).
- CASET 00 05 then command 0x2C, then 1 pixel -> window is unchanged (SC = 0); the pixel lands at (0,0). Asserting rst low mid-pixel clears all outputs within the same clk edge region, and the window returns to defaults.
